coeff_bank_loader: RTL and testbench

Control-path block that configures the three-axis FIR signal path. It accepts a bank-load command from a host requester and streams 16 coefficient words into a non-live bank over the signal path's update port (`update_en`/`update_axis`/`update_bank`/`update_index`/`update_value`). It owns the per-axis active-bank selects (`x_bank`/`y_bank`/`z_bank`). Bank switches are applied only while the signal path reports `available`, so a filter pass never sees a mixed coefficient set.

---
 rtl/coeff_bank_loader_if.sv | 47 ++++
 rtl/coeff_bank_loader.sv | 140 ++++++++++++++
 tb/tb_coeff_bank_loader.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/coeff_bank_loader_if.sv
`default_nettype none
// ============================================================================
// coeff_bank_loader_if : host command, coefficient stream and FIR update bundle
// Rev 1.0
// ============================================================================
interface coeff_bank_loader_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_axis;
  logic [1:0]  cmd_bank;
  logic        cmd_swap;
  logic        data_valid;
  logic        data_ready;
  logic [15:0] data_value;
  logic        available;
  logic        update_en;
  logic [1:0]  update_axis;
  logic [1:0]  update_bank;
  logic [3:0]  update_index;
  logic [15:0] update_value;
  logic [1:0]  x_bank;
  logic [1:0]  y_bank;
  logic [1:0]  z_bank;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  modport slave (
    input  cmd_valid, cmd_axis, cmd_bank, cmd_swap,
    input  data_valid, data_value, available,
    output cmd_ready, data_ready,
    output update_en, update_axis, update_bank, update_index, update_value,
    output x_bank, y_bank, z_bank,
    output busy, done, err, err_code
  );

  modport master (
    output cmd_valid, cmd_axis, cmd_bank, cmd_swap,
    output data_valid, data_value, available,
    input  cmd_ready, data_ready,
    input  update_en, update_axis, update_bank, update_index, update_value,
    input  x_bank, y_bank, z_bank,
    input  busy, done, err, err_code
  );
endinterface
`default_nettype wire

// File: rtl/coeff_bank_loader.sv
`default_nettype none
// ============================================================================
// coeff_bank_loader : streams 16 FIR coefficients into a non-live bank and
//                     optionally makes it live between samples
// Rev 1.0
// ============================================================================
module coeff_bank_loader #(
  parameter int         TIMEOUT      = 1000,
  parameter logic [1:0] X_RESET_BANK = 2'd0,
  parameter logic [1:0] Y_RESET_BANK = 2'd0,
  parameter logic [1:0] Z_RESET_BANK = 2'd0
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  coeff_bank_loader_if.slave bus
);

  localparam int              c_TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_TW-1:0] c_IDLE_MAX  = c_TW'(TIMEOUT - 1);
  localparam logic [1:0]      c_ERR_AXIS  = 2'd1;
  localparam logic [1:0]      c_ERR_LIVE  = 2'd2;
  localparam logic [1:0]      c_ERR_TMO   = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    SWAP_WAIT = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t          r_state;
  logic [1:0]      r_axis;
  logic [1:0]      r_bank;
  logic            r_swap;
  logic [3:0]      r_beat;
  logic [c_TW-1:0] r_idle;
  logic [1:0]      w_cur_bank;

  // Live bank of the axis named by the incoming command, for the legality check
  always_comb begin
    w_cur_bank = bus.x_bank;
    case (bus.cmd_axis)
      2'd2:    w_cur_bank = bus.y_bank;
      2'd3:    w_cur_bank = bus.z_bank;
      default: w_cur_bank = bus.x_bank;
    endcase
  end

  assign bus.cmd_ready  = rst_n && (r_state == IDLE);
  assign bus.data_ready = (r_state == LOAD);
  assign bus.busy       = (r_state != IDLE);

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_state          <= IDLE;
      r_axis           <= 2'd0;
      r_bank           <= 2'd0;
      r_swap           <= 1'b0;
      r_beat           <= 4'd0;
      r_idle           <= '0;
      bus.update_en    <= 1'b0;
      bus.update_axis  <= 2'd0;
      bus.update_bank  <= 2'd0;
      bus.update_index <= 4'd0;
      bus.update_value <= 16'd0;
      bus.x_bank       <= X_RESET_BANK;
      bus.y_bank       <= Y_RESET_BANK;
      bus.z_bank       <= Z_RESET_BANK;
      bus.done         <= 1'b0;
      bus.err          <= 1'b0;
      bus.err_code     <= 2'd0;
    end else begin
      bus.update_en <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.cmd_valid) begin
            r_axis <= bus.cmd_axis;
            r_bank <= bus.cmd_bank;
            r_swap <= bus.cmd_swap;
            if (bus.cmd_axis == 2'd0) begin
              bus.err      <= 1'b1;
              bus.err_code <= c_ERR_AXIS;
            end else if (bus.cmd_bank == w_cur_bank) begin
              bus.err      <= 1'b1;
              bus.err_code <= c_ERR_LIVE;
            end else begin
              r_state <= LOAD;
              r_beat  <= 4'd0;
              r_idle  <= '0;
            end
          end
        end
        LOAD: begin
          if (bus.data_valid) begin
            bus.update_en    <= 1'b1;
            bus.update_axis  <= r_axis;
            bus.update_bank  <= r_bank;
            bus.update_index <= r_beat;
            bus.update_value <= bus.data_value;
            r_beat           <= r_beat + 4'd1;
            r_idle           <= '0;
            if (r_beat == 4'd15) begin
              if (r_swap) begin
                r_state <= SWAP_WAIT;
              end else begin
                r_state  <= DONE;
                bus.done <= 1'b1;
              end
            end
          end else if (r_idle == c_IDLE_MAX) begin
            // Partial writes stay in the inactive bank; the live select is untouched
            r_state      <= IDLE;
            bus.err      <= 1'b1;
            bus.err_code <= c_ERR_TMO;
          end else begin
            r_idle <= r_idle + 1'b1;
          end
        end
        SWAP_WAIT: begin
          if (bus.available) begin
            case (r_axis)
              2'd1:    bus.x_bank <= r_bank;
              2'd2:    bus.y_bank <= r_bank;
              2'd3:    bus.z_bank <= r_bank;
              default: ;
            endcase
            r_state  <= DONE;
            bus.done <= 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_coeff_bank_loader.sv
`default_nettype none
// ============================================================================
// tb_coeff_bank_loader : directed bench with a transaction-level model
// Rev 1.0
// ============================================================================
module tb_coeff_bank_loader;

  localparam int TO = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  coeff_bank_loader_if bus();

  coeff_bank_loader #(
    .TIMEOUT     (TO),
    .X_RESET_BANK(2'd0),
    .Y_RESET_BANK(2'd0),
    .Z_RESET_BANK(2'd0)
  ) dut (
    .sys_clk(clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic [1:0]  axis;
    logic [1:0]  bank;
    logic [3:0]  idx;
    logic [15:0] val;
  } wr_t;

  wr_t        wq[$];
  logic [2:0] evq[$];   // {is_err, code}; 3'b000 means a done pulse
  logic [1:0] exp_bank [0:3];

  int n_vec = 0, n_fail = 0;
  int cyc = 0, n_wr = 0, busy_cnt = 0, done_cnt = 0;
  int run = 0, max_run = 0, last_wr_cyc = 0, last_err_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm, input logic [31:0] act);
    n_vec++;
    n_fail++;
    $display("FAIL %s: got %0h, required nothing", nm, act);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.update_en === 1'b1) begin
      n_wr++;
      run++;
      if (run > max_run) max_run = run;
      last_wr_cyc = cyc;
      if (wq.size() == 0)
        flag("unexpected_write", 32'({bus.update_axis, bus.update_bank, bus.update_index, bus.update_value}));
      else begin
        chk("write", 32'({bus.update_axis, bus.update_bank, bus.update_index, bus.update_value}), 32'(wq[0]));
        void'(wq.pop_front());
      end
    end else begin
      run = 0;
    end
    if (bus.busy === 1'b1) busy_cnt++;
    if (bus.done === 1'b1 || bus.err === 1'b1) begin
      chk("done_err_exclusive", 32'(bus.done & bus.err), 32'd0);
      if (bus.done === 1'b1) done_cnt++;
      if (bus.err === 1'b1) last_err_cyc = cyc;
      if (evq.size() == 0)
        flag("unexpected_event", 32'({bus.done, bus.err, bus.err_code}));
      else begin
        chk("event", 32'((bus.err === 1'b1) ? {1'b1, bus.err_code} : 3'b000), 32'(evq[0]));
        void'(evq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] a, input logic [1:0] b, input logic s);
    bus.cmd_valid = 1'b1;
    bus.cmd_axis  = a;
    bus.cmd_bank  = b;
    bus.cmd_swap  = s;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_beats(input logic [1:0] a, input logic [1:0] b, input int start,
                            input int n, input logic [15:0] base);
    wr_t w;
    for (int i = start; i < start + n; i++) begin
      bus.data_valid = 1'b1;
      bus.data_value = base + 16'(i);
      w.axis = a;
      w.bank = b;
      w.idx  = 4'(i);
      w.val  = base + 16'(i);
      wq.push_back(w);
      tick();
    end
    bus.data_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while ((bus.busy !== 1'b0 || evq.size() != 0) && k < 300) begin
      tick();
      k++;
    end
    if (k >= 300) flag({nm, "_idle_timeout"}, 32'(evq.size()));
    tick();
  endtask

  task automatic check_banks(input string nm);
    chk({nm, "_x_bank"}, 32'(bus.x_bank), 32'(exp_bank[1]));
    chk({nm, "_y_bank"}, 32'(bus.y_bank), 32'(exp_bank[2]));
    chk({nm, "_z_bank"}, 32'(bus.z_bank), 32'(exp_bank[3]));
    chk({nm, "_writes_left"}, 32'(wq.size()), 32'd0);
  endtask

  // Model: outcome of a command is decided by legality, beats supplied and
  // gap length; available is assumed high so a swap costs one cycle.
  task automatic run_cmd(input string nm, input logic [1:0] a, input logic [1:0] b,
                         input logic s, input int n1, input int gap, input logic [15:0] base);
    int   wr0, exp_busy, exp_wr;
    logic legal, tmo;
    legal = (a != 2'd0) && (b != exp_bank[a]);
    tmo   = legal && (n1 < 16) && (gap >= TO);
    if (!legal)   evq.push_back({1'b1, (a == 2'd0) ? 2'd1 : 2'd2});
    else if (tmo) evq.push_back(3'b111);
    else          evq.push_back(3'b000);
    exp_busy = !legal ? 0 : tmo ? n1 + TO : 16 + ((n1 < 16) ? gap : 0) + int'(s) + 1;
    exp_wr   = !legal ? 0 : tmo ? n1 : 16;
    busy_cnt = 0;
    wr0      = n_wr;
    chk({nm, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    send_cmd(a, b, s);
    if (legal) begin
      send_beats(a, b, 0, n1, base);
      if (!tmo && n1 < 16) begin
        repeat (gap) tick();
        send_beats(a, b, n1, 16 - n1, base);
      end
    end
    wait_idle(nm);
    if (legal && !tmo && s) exp_bank[a] = b;
    chk({nm, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    chk({nm, "_write_count"}, 32'(n_wr - wr0), 32'(exp_wr));
    if (tmo) chk({nm, "_timeout_latency"}, 32'(last_err_cyc - last_wr_cyc), 32'(TO));
    check_banks(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got time %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    for (int i = 0; i < 4; i++) exp_bank[i] = 2'd0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_axis   = 2'd0;
    bus.cmd_bank   = 2'd0;
    bus.cmd_swap   = 1'b0;
    bus.data_valid = 1'b0;
    bus.data_value = 16'd0;
    bus.available  = 1'b1;

    repeat (3) tick();
    chk("rst_cmd_ready_low", 32'(bus.cmd_ready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_pulses", 32'({bus.done, bus.err, bus.update_en, bus.data_ready}), 32'd0);
    chk("rst_err_code", 32'(bus.err_code), 32'd0);
    chk("rst_update", 32'({bus.update_axis, bus.update_bank, bus.update_index, bus.update_value}), 32'd0);
    check_banks("rst");

    // Full load on x with swap
    max_run = 0;
    d0 = done_cnt;
    run_cmd("T1", 2'd1, 2'd2, 1'b1, 16, 0, 16'h0100);
    chk("T1_x_bank_lit", 32'(bus.x_bank), 32'd2);
    chk("T1_busy_lit", 32'(busy_cnt), 32'd18);
    chk("T1_run_lit", 32'(max_run), 32'd16);
    chk("T1_done_lit", 32'(done_cnt - d0), 32'd1);
    chk("T1_hold_lit", 32'({bus.update_index, bus.update_value}), 32'h0F010F);

    // Target already live, then illegal axis
    run_cmd("T2", 2'd2, 2'd0, 1'b0, 16, 0, 16'h0);
    chk("T2_err_code_lit", 32'(bus.err_code), 32'd2);
    run_cmd("T3", 2'd0, 2'd1, 1'b0, 16, 0, 16'h0);
    chk("T3_err_code_lit", 32'(bus.err_code), 32'd1);

    // Stall after 5 beats: timeout abort
    run_cmd("T4", 2'd3, 2'd1, 1'b0, 5, TO, 16'h3000);
    chk("T4_err_code_lit", 32'(bus.err_code), 32'd3);
    chk("T4_z_bank_lit", 32'(bus.z_bank), 32'd0);

    // Beat lands in the cycle the idle count would hit TIMEOUT: no abort
    run_cmd("T7", 2'd2, 2'd1, 1'b0, 3, TO - 1, 16'h6000);
    chk("T7_busy_lit", 32'(busy_cnt), 32'd24);
    chk("T7_err_code_hold", 32'(bus.err_code), 32'd3);
    chk("T7_y_bank_lit", 32'(bus.y_bank), 32'd0);

    // Swap held off by available=0 for 50 cycles
    bus.available = 1'b0;
    evq.push_back(3'b000);
    busy_cnt = 0;
    send_cmd(2'd2, 2'd3, 1'b1);
    send_beats(2'd2, 2'd3, 0, 16, 16'h2A00);
    for (int i = 0; i < 50; i++) begin
      chk("T5_y_bank_wait", 32'(bus.y_bank), 32'(exp_bank[2]));
      chk("T5_busy_wait", 32'(bus.busy), 32'd1);
      tick();
    end
    bus.available = 1'b1;
    wait_idle("T5");
    exp_bank[2] = 2'd3;
    check_banks("T5");
    chk("T5_y_bank_lit", 32'(bus.y_bank), 32'd3);
    chk("T5_busy_lit", 32'(busy_cnt), 32'd68);

    // Reset during beat 7
    d0 = done_cnt;
    send_cmd(2'd1, 2'd1, 1'b1);
    send_beats(2'd1, 2'd1, 0, 7, 16'h3300);
    bus.data_valid = 1'b1;
    bus.data_value = 16'h3307;
    rst_n = 1'b0;
    tick();
    bus.data_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("T6_rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("T6_rst_quiet", 32'({bus.update_en, bus.busy, bus.done, bus.err}), 32'd0);
      tick();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) exp_bank[i] = 2'd0;
    tick();
    check_banks("T6_rst");
    chk("T6_no_done", 32'(done_cnt - d0), 32'd0);
    run_cmd("T6", 2'd1, 2'd3, 1'b1, 16, 0, 16'h4400);
    chk("T6_x_bank_lit", 32'(bus.x_bank), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
